// File: rtl/serial_divider.sv
// serial_divider: unsigned restoring divider that produces one quotient bit per clock.
//
// Parameters
//   SIZE        operand, quotient and remainder width in bits (>= 2)
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   start       request a division; accepted only while idle
//   dividend    unsigned numerator, sampled when start is accepted
//   divisor     unsigned denominator, sampled when start is accepted
//   busy        high while iterating
//   done        one-cycle pulse when quotient/remainder/div_by_zero are fresh
//   quotient    unsigned result (all ones on a zero divisor)
//   remainder   unsigned remainder (the dividend on a zero divisor)
//   div_by_zero set with a result whose divisor was zero
module serial_divider #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_by_zero
);

  localparam int          CW   = $clog2(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SIZE:0]   rem_q, rem_d;        // partial remainder, one bit wider than the operands
  logic [SIZE-1:0] dvd_q, dvd_d;        // dividend, shifted out MSB first
  logic [SIZE-1:0] dvs_q, dvs_d;
  logic [SIZE-1:0] qacc_q, qacc_d;      // quotient bits collected during RUN
  logic [SIZE-1:0] quotient_q, quotient_d;
  logic [SIZE-1:0] remainder_q, remainder_d;
  logic            dbz_q, dbz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [SIZE:0]   shifted_s;
  logic [SIZE+1:0] diff_s;
  logic            borrow_s;
  logic [SIZE:0]   next_rem_s;
  logic [SIZE-1:0] next_qacc_s;

  // One restoring step: shift in the next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    shifted_s   = (rem_q << 1) | {{SIZE{1'b0}}, dvd_q[SIZE-1]};
    diff_s      = {1'b0, shifted_s} - {2'b00, dvs_q};
    borrow_s    = diff_s[SIZE+1];
    next_rem_s  = borrow_s ? shifted_s : diff_s[SIZE:0];
    next_qacc_s = (qacc_q << 1) | {{(SIZE-1){1'b0}}, ~borrow_s};
  end

  // Next-state, datapath and result-register update.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    qacc_d      = qacc_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != {SIZE{1'b0}}) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            rem_d   = {(SIZE+1){1'b0}};
            qacc_d  = {SIZE{1'b0}};
            count_d = {CW{1'b0}};
            state_d = RUN;
          end else begin
            // Zero divisor skips RUN and reports immediately.
            quotient_d  = {SIZE{1'b1}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d  = next_rem_s;
        qacc_d = next_qacc_s;
        dvd_d  = dvd_q << 1;
        if (count_q == LAST) begin
          // Final step: the remainder is below the divisor, so it fits SIZE bits.
          quotient_d  = next_qacc_s;
          remainder_d = next_rem_s[SIZE-1:0];
          dbz_d       = 1'b0;
          count_d     = {CW{1'b0}};
          state_d     = DONE;
        end else begin
          count_d = count_q + CW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= {CW{1'b0}};
      rem_q       <= {(SIZE+1){1'b0}};
      dvd_q       <= {SIZE{1'b0}};
      dvs_q       <= {SIZE{1'b0}};
      qacc_q      <= {SIZE{1'b0}};
      quotient_q  <= {SIZE{1'b0}};
      remainder_q <= {SIZE{1'b0}};
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      qacc_q      <= qacc_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_serial_divider.sv
// Directed bench for serial_divider (SIZE=16). Edge 0 of an operation is the
// edge just before start is driven; done is expected 17 edges later for a
// nonzero divisor and 1 edge later for a zero divisor.
module tb_serial_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;
  logic [15:0] prev_q = 16'h0000;

  serial_divider #(.SIZE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one division and check latency, busy length, results and hold behaviour.
  // inj_at > 0 pulses start with other operands during RUN at that cycle.
  task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                        input int elat, input int ebusy, input int inj_at);
    int cycles;
    int busy_cnt;
    bit seen;
    cycles   = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    while (!seen && cycles < 40) begin
      step();
      start = 1'b0;
      cycles++;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      if (!seen && cycles == 8) chk({tag, "_hold_q"}, 32'(quotient), 32'(prev_q));
      if (!seen && cycles == inj_at) begin
        dividend = 16'hFFFF;
        divisor  = 16'h0001;
        start    = 1'b1;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(cycles), 32'(elat));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(ebusy));
    chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_q_held"}, 32'(quotient), 32'(eq));
    prev_q = eq;
  endtask

  initial begin
    bit seen_done;
    bit seen_busy;
    rst      = 1'b0;
    start    = 1'b0;
    dividend = 16'h0000;
    divisor  = 16'h0000;
    #2 rst = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    step();
    step();
    rst = 1'b0;

    do_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16, 0);
    do_div("ffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17, 16, 0);
    do_div("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17, 16, 0);
    do_div("d3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17, 16, 0);
    do_div("d5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1, 0, 0);
    do_div("inj_100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16, 5);
    do_div("d1000_33", 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 17, 16, 0);

    // Abort mid-RUN after 8 iterations.
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    rst   = 1'b0;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    chk("abort_no_busy", 32'(seen_busy), 32'd0);
    prev_q = 16'h0000;
    do_div("post_abort", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
